// File: rtl/n64_controller_responder.sv
// rtl/n64_controller_responder.sv - N64 controller-side responder on the shared open-drain data line.
// Decodes the console command byte and answers with the identity or button/stick frame.
module n64_controller_responder #(
  parameter int CYCLES_PER_US = 100,
  parameter int TURNAROUND_US = 2,
  parameter int RX_TIMEOUT_US = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_in,
  output logic        line_oe,
  input  logic [15:0] buttons,
  input  logic [7:0]  stick_x,
  input  logic [7:0]  stick_y,
  output logic        cmd_valid,
  output logic [7:0]  cmd,
  output logic        busy,
  output logic        rx_err
);

  localparam int TW = $clog2(RX_TIMEOUT_US * CYCLES_PER_US + 1);
  localparam logic [TW-1:0] T_SAMPLE = TW'(2 * CYCLES_PER_US - 1);
  localparam logic [TW-1:0] T_CELL   = TW'(4 * CYCLES_PER_US - 1);
  localparam logic [TW-1:0] T_TA     = TW'(TURNAROUND_US * CYCLES_PER_US - 1);
  localparam logic [TW-1:0] T_TO     = TW'(RX_TIMEOUT_US * CYCLES_PER_US - 1);
  localparam logic [TW-1:0] T_STOP   = TW'(2 * CYCLES_PER_US - 1);
  localparam logic [TW-1:0] T_LOW1   = TW'(CYCLES_PER_US);
  localparam logic [TW-1:0] T_LOW0   = TW'(3 * CYCLES_PER_US);
  localparam logic [TW-1:0] T_MAX    = '1;

  typedef enum logic [2:0] {
    IDLE, RX_SAMPLE, RX_WAIT, RX_STOP, IGNORE, TURNAROUND, TX_BIT, TX_STOP
  } state_t;

  state_t        state, state_n;
  logic          line_meta, line_sync, line_prev;
  logic [TW-1:0] timer;
  logic          timer_clr;
  logic [4:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    rx_sr, rx_sr_n, cmd_n;
  logic [31:0]   tx_sr, tx_sr_n;
  logic          valid_n, err_n, oe_n, fall;

  assign fall = line_prev & ~line_sync;
  assign busy = (state != IDLE);

  // Synchroniser resets to the idle-high level so release of reset never looks like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_meta <= 1'b1;
      line_sync <= 1'b1;
      line_prev <= 1'b1;
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      rx_err    <= 1'b0;
      line_oe   <= 1'b0;
    end else begin
      line_meta <= line_in;
      line_sync <= line_meta;
      line_prev <= line_sync;
      state     <= state_n;
      timer     <= timer_clr ? '0 : ((timer == T_MAX) ? timer : timer + 1'b1);
      bit_cnt   <= bit_cnt_n;
      rx_sr     <= rx_sr_n;
      tx_sr     <= tx_sr_n;
      cmd       <= cmd_n;
      cmd_valid <= valid_n;
      rx_err    <= err_n;
      line_oe   <= oe_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_clr = 1'b0;
    bit_cnt_n = bit_cnt;
    rx_sr_n   = rx_sr;
    tx_sr_n   = tx_sr;
    cmd_n     = cmd;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    oe_n      = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_n   = RX_SAMPLE;
          timer_clr = 1'b1;
          bit_cnt_n = '0;
        end
      end
      RX_SAMPLE: begin
        if (timer == T_SAMPLE) begin
          rx_sr_n   = {rx_sr[6:0], line_sync};
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd7) begin
            cmd_n   = {rx_sr[6:0], line_sync};
            valid_n = 1'b1;
          end
        end else if (timer > T_SAMPLE && line_sync) begin
          state_n   = RX_WAIT;
          timer_clr = 1'b1;
        end else if (timer >= T_CELL) begin
          err_n     = 1'b1;
          state_n   = IGNORE;
          timer_clr = 1'b1;
        end
      end
      RX_WAIT: begin
        if (fall) begin
          state_n   = (bit_cnt == 5'd8) ? RX_STOP : RX_SAMPLE;
          timer_clr = 1'b1;
        end else if (!line_sync && timer >= T_CELL) begin
          err_n     = 1'b1;
          state_n   = IGNORE;
          timer_clr = 1'b1;
        end else if (line_sync && timer >= T_TO) begin
          err_n     = 1'b1;
          state_n   = IDLE;
          timer_clr = 1'b1;
        end
      end
      RX_STOP: begin
        if (line_sync) begin
          timer_clr = 1'b1;
          case (cmd)
            8'h00, 8'hFF: begin
              tx_sr_n   = {24'h050002, 8'h00};
              bit_cnt_n = 5'd23;
              state_n   = TURNAROUND;
            end
            8'h01: begin
              tx_sr_n   = {buttons, stick_x, stick_y};
              bit_cnt_n = 5'd31;
              state_n   = TURNAROUND;
            end
            default: begin
              err_n   = 1'b1;
              state_n = IGNORE;
            end
          endcase
        end else if (timer >= T_CELL) begin
          err_n     = 1'b1;
          state_n   = IGNORE;
          timer_clr = 1'b1;
        end
      end
      IGNORE: begin
        if (!line_sync) begin
          timer_clr = 1'b1;
        end else if (timer >= T_TO) begin
          state_n   = IDLE;
          timer_clr = 1'b1;
        end
      end
      TURNAROUND: begin
        if (timer >= T_TA) begin
          state_n   = TX_BIT;
          timer_clr = 1'b1;
        end
      end
      TX_BIT: begin
        oe_n = (timer < (tx_sr[31] ? T_LOW1 : T_LOW0));
        if (timer >= T_CELL) begin
          timer_clr = 1'b1;
          tx_sr_n   = {tx_sr[30:0], 1'b0};
          if (bit_cnt == 5'd0) state_n = TX_STOP;
          else bit_cnt_n = bit_cnt - 5'd1;
        end
      end
      TX_STOP: begin
        oe_n = 1'b1;
        if (timer >= T_STOP) begin
          state_n   = IDLE;
          timer_clr = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/n64_controller_responder.md
Name: n64_controller_responder

Overview:
- Device-side end of the N64 single-wire protocol; the console-side block issues polls and reads buttons.
- Lets the fabric emulate a controller on the shared open-drain data line.
- Decodes the console command byte, then transmits the identity or button/stick response with N64 bit timing.
- Sits beside the FAB_CLK-domain poll and read blocks; the button word comes from fabric logic or the MSS.

Parameters:
- CYCLES_PER_US, 100, clk cycles per microsecond; all timing derives from this.
- TURNAROUND_US, 2, idle time from end of console stop bit to first response bit.
- RX_TIMEOUT_US, 8, continuous line-high time that aborts a partial or ignored command.

Ports:
- clk  in  1  fabric clock (FAB_CLK).
- rst_n  in  1  asynchronous active-low reset.
- line_in  in  1  data line sense; asynchronous, synchronised internally with a 2-FF synchroniser.
- line_oe  out  1  open-drain drive; 1 pulls the line low, 0 releases it.
- buttons  in  16  button word; bit 15 is transmitted first.
- stick_x  in  8  signed X axis.
- stick_y  in  8  signed Y axis.
- cmd_valid  out  1  one-cycle pulse when a command byte completes.
- cmd  out  8  last received command byte; held until the next one.
- busy  out  1  high from first falling edge of a command until TX stop bit ends.
- rx_err  out  1  one-cycle pulse on timeout or ignored command.

Behaviour:
Reset (asynchronous, immediate):
- line_oe=0, cmd_valid=0, cmd=0x00, busy=0, rx_err=0.
- FSM goes to IDLE.
- Reset during TX releases the line at once.

Bit coding (both directions, MSB first):
- Bit cell is 4 us.
- '0' = 3 us low + 1 us high.
- '1' = 1 us low + 3 us high.

RX:
- Falling edge of the synchronised line starts a bit.
- Line is sampled 2*CYCLES_PER_US cycles after the edge: high gives '1', low gives '0'.
- Sampled bit shifts into an 8-bit register.
- After 8 bits: cmd updates, cmd_valid pulses in the same cycle.

FSM states:
- IDLE: line_oe=0, busy=0. Falling edge goes to RX_SAMPLE.
- RX_SAMPLE: wait the 2 us sample point, shift the bit.
  - If the line is still low after 4 us: timeout, go to IGNORE.
  - Otherwise go to RX_WAIT.
- RX_WAIT: wait for the next falling edge.
  - Bit count < 8: go to RX_SAMPLE.
  - Bit count == 8: this edge is the console stop bit; go to RX_STOP.
  - Line high for RX_TIMEOUT_US: rx_err pulse, go to IDLE.
- RX_STOP: wait for the line to return high.
  - Command 0x00 or 0xFF: load a 24-bit response 0x050002, go to TURNAROUND.
  - Command 0x01: load a 32-bit response {buttons, stick_x, stick_y}, go to TURNAROUND.
  - Any other command: rx_err pulse, go to IGNORE.
- Snapshot: the response shift register is loaded in the RX_STOP exit cycle. Input changes during TX do not affect the frame.
- IGNORE: wait for the line to stay high RX_TIMEOUT_US, then go to IDLE. This swallows trailing address/data bytes.
- TURNAROUND: count TURNAROUND_US, then go to TX_BIT.
- TX_BIT: drive each bit with the cell timing above.
  - Bit counter runs 23 (info) or 31 (poll) down to 0.
- TX_STOP: line_oe=1 for 2 us, then 0, then go to IDLE.
  - IDLE requires the line to be sensed high before accepting a new edge.

Echo and timing rules:
- line_in is ignored from TURNAROUND through TX_STOP, so there is no self-echo.
- Timer width is clog2(RX_TIMEOUT_US*CYCLES_PER_US+1).
- Timer restarts at every state change and every bit boundary.
- Line still low at the 4 us point in RX_WAIT means a stuck bus: rx_err, then IGNORE.

Test Plan:
1. Console sends 0x01 + stop; buttons=0x8001, stick_x=0x7F, stick_y=0x80 -> cmd_valid pulse with cmd=0x01; after 200 cycles of turnaround, 32 cells of 400 cycles each; first cell low 100 cycles; decoded frame equals 0x8001_7F80; stop low 200 cycles; busy falls after the stop.
2. Console sends 0x00 -> 24-bit frame decodes to 0x050002. Repeat with 0xFF -> same frame.
3. Console sends 0x02 followed by 16 address bits -> rx_err pulse after the 8th bit; line_oe stays 0 throughout; IDLE 800 cycles after the last edge; a following 0x01 is answered normally.
4. Console stops after 5 bits -> rx_err after 800 high cycles; next full 0x01 decodes correctly (no stale bits).
5. buttons toggled every 50 cycles during TX -> transmitted word equals the value present at RX_STOP exit.
6. rst_n asserted at bit 10 of TX -> line_oe=0 in the same cycle; after release, the block idles until the next command and responds correctly.
